// File: rtl/fetch_unit.sv
// IF stage: owns the fetch PC, runs the instruction-memory request handshake and
// loads the IF/ID register, absorbing wait states, stalls, redirects and pauses.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall_d,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        pause_d,
    input  logic        resume,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pcplus4_d,
    output logic        valid_d,
    output logic        paused
);
    typedef enum logic {RUN, PAUSED} state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;

    state_t      state_reg;
    logic [31:0] fetch_pc_reg;
    logic [31:0] hold_addr_reg;
    logic        outstanding_reg;
    logic        drop_reg;
    logic        skid_v_reg;
    logic [31:0] skid_instr_reg;
    logic [31:0] skid_pc_reg;
    logic [31:0] instr_reg;
    logic [31:0] pc_reg;
    logic [31:0] pcplus4_reg;
    logic        valid_reg;

    logic        xfer;
    logic        keep;
    logic        miss;
    logic        pause_fire;
    logic [31:0] addr_plus4;

    // A request that was not accepted keeps its original address even if the
    // fetch PC has since been retargeted by a redirect or pause.
    assign imem_req   = ((state_reg == RUN) && !skid_v_reg) || outstanding_reg;
    assign imem_addr  = outstanding_reg ? hold_addr_reg : fetch_pc_reg;
    assign addr_plus4 = imem_addr + 32'd4;

    assign xfer       = imem_req && imem_ready;
    assign keep       = xfer && !drop_reg;
    assign miss       = imem_req && !imem_ready;
    assign pause_fire = (state_reg == RUN) && pause_d && valid_reg && !stall_d && !redirect;

    assign instr_d   = instr_reg;
    assign pc_d      = pc_reg;
    assign pcplus4_d = pcplus4_reg;
    assign valid_d   = valid_reg;
    assign paused    = (state_reg == PAUSED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= RUN;
            fetch_pc_reg    <= RESET_PC_ALIGNED;
            hold_addr_reg   <= RESET_PC_ALIGNED;
            outstanding_reg <= 1'b0;
            drop_reg        <= 1'b0;
            skid_v_reg      <= 1'b0;
            skid_instr_reg  <= 32'h0;
            skid_pc_reg     <= 32'h0;
            instr_reg       <= 32'h0;
            pc_reg          <= 32'h0;
            pcplus4_reg     <= 32'h0;
            valid_reg       <= 1'b0;
        end else begin
            outstanding_reg <= miss;
            hold_addr_reg   <= imem_addr;

            // An abandoned in-flight request must have its word discarded on arrival.
            if ((redirect || pause_fire) && miss) begin
                drop_reg <= 1'b1;
            end else if (xfer) begin
                drop_reg <= 1'b0;
            end

            if (redirect) begin
                fetch_pc_reg <= redirect_pc & ~32'h3;
            end else if (pause_fire) begin
                fetch_pc_reg <= pcplus4_reg;
            end else if (keep) begin
                fetch_pc_reg <= addr_plus4;
            end

            if ((state_reg == PAUSED) && resume) begin
                state_reg <= RUN;
            end else if (pause_fire) begin
                state_reg <= PAUSED;
            end

            if (redirect || pause_fire) begin
                instr_reg   <= 32'h0;
                pc_reg      <= 32'h0;
                pcplus4_reg <= 32'h0;
                valid_reg   <= 1'b0;
                skid_v_reg  <= 1'b0;
            end else if (stall_d) begin
                if (keep) begin
                    skid_v_reg     <= 1'b1;
                    skid_instr_reg <= imem_rdata;
                    skid_pc_reg    <= imem_addr;
                end
            end else if (skid_v_reg) begin
                instr_reg   <= skid_instr_reg;
                pc_reg      <= skid_pc_reg;
                pcplus4_reg <= skid_pc_reg + 32'd4;
                valid_reg   <= 1'b1;
                skid_v_reg  <= 1'b0;
            end else if (keep) begin
                instr_reg   <= imem_rdata;
                pc_reg      <= imem_addr;
                pcplus4_reg <= addr_plus4;
                valid_reg   <= 1'b1;
            end else begin
                instr_reg   <= 32'h0;
                pc_reg      <= 32'h0;
                pcplus4_reg <= 32'h0;
                valid_reg   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a scoreboard of expected IF/ID PCs filled as
// transfers are provoked, drained whenever a fresh instruction reaches decode.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall_d;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        pause_d;
    logic        resume;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;
    logic        valid_d;
    logic        paused;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic        held_prev = 1'b0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .stall_d    (stall_d),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .pause_d    (pause_d),
        .resume     (resume),
        .instr_d    (instr_d),
        .pc_d       (pc_d),
        .pcplus4_d  (pcplus4_d),
        .valid_d    (valid_d),
        .paused     (paused)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endfunction

    assign imem_rdata = word_of(imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // IF/ID only presents a new instruction when it was not held at the last edge.
    always @(posedge clk) held_prev <= stall_d && !redirect;

    always @(negedge clk) begin
        if (rst_n && valid_d && !held_prev) begin
            if (exp_q.size() == 0) begin
                vectors++;
                assert (exp_q.size() != 0) else begin
                    miscompares++;
                    $error("FAIL sb_unexpected: observed pc_d %h expected no instruction", pc_d);
                end
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("sb_pc_d", pc_d, e);
                check("sb_instr_d", instr_d, word_of(e));
                check("sb_pcplus4_d", pcplus4_d, e + 32'd4);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        imem_ready = 1'b1; stall_d = 1'b0; redirect = 1'b0;
        redirect_pc = 32'h0; pause_d = 1'b0; resume = 1'b0;
        tick(); tick();
        check("rst_valid", {31'h0, valid_d}, 32'h0);
        check("rst_instr", instr_d, 32'h0);
        check("rst_pc", pc_d, 32'h0);
        check("rst_pcplus4", pcplus4_d, 32'h0);
        check("rst_paused", {31'h0, paused}, 32'h0);
        check("rst_req", {31'h0, imem_req}, 32'h1);
        rst_n = 1'b1;

        // Streaming fetch with memory always ready
        check("t1_addr0", imem_addr, 32'h0);
        check("t1_valid0", {31'h0, valid_d}, 32'h0);
        exp_q.push_back(32'h0); tick();
        check("t1_addr4", imem_addr, 32'h4);
        exp_q.push_back(32'h4); tick();
        check("t1_addr8", imem_addr, 32'h8);

        // Three wait states at 0x8
        imem_ready = 1'b0; tick();
        for (int i = 0; i < 3; i++) begin
            check("t2_addr", imem_addr, 32'h8);
            check("t2_req", {31'h0, imem_req}, 32'h1);
            check("t2_bubble", {31'h0, valid_d}, 32'h0);
            if (i == 2) begin
                imem_ready = 1'b1;
                exp_q.push_back(32'h8);
            end
            tick();
        end

        // Decode stall while 0xC transfers into the skid
        check("t3_addrC", imem_addr, 32'hC);
        check("t3_pc8", pc_d, 32'h8);
        stall_d = 1'b1; exp_q.push_back(32'hC); tick();
        check("t3_req_low", {31'h0, imem_req}, 32'h0);
        check("t3_hold_pc", pc_d, 32'h8);
        check("t3_hold_valid", {31'h0, valid_d}, 32'h1);
        stall_d = 1'b0; tick();
        check("t3_pcC", pc_d, 32'hC);
        check("t3_addr10", imem_addr, 32'h10);

        // Redirect while 0x10 is waiting on memory
        imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h103; tick();
        redirect = 1'b0;
        check("t4_bubble", {31'h0, valid_d}, 32'h0);
        check("t4_addr_held", imem_addr, 32'h10);
        check("t4_req_held", {31'h0, imem_req}, 32'h1);
        tick();
        check("t4_addr_held2", imem_addr, 32'h10);
        imem_ready = 1'b1; tick();
        check("t4_drop_bubble", {31'h0, valid_d}, 32'h0);
        check("t4_addr100", imem_addr, 32'h100);
        exp_q.push_back(32'h100); tick();
        check("t4_pc100", pc_d, 32'h100);
        check("t4_addr104", imem_addr, 32'h104);

        // Steer to 0x18 so the pausing instruction lands at 0x20
        redirect = 1'b1; redirect_pc = 32'h18; tick();
        redirect = 1'b0;
        check("t5_bubble", {31'h0, valid_d}, 32'h0);
        check("t5_addr18", imem_addr, 32'h18);
        exp_q.push_back(32'h18); tick();
        exp_q.push_back(32'h1C); tick();
        exp_q.push_back(32'h20); tick();
        check("t5_pc20", pc_d, 32'h20);
        check("t5_addr24", imem_addr, 32'h24);
        pause_d = 1'b1; tick();
        pause_d = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("t5_paused", {31'h0, paused}, 32'h1);
            check("t5_req_low", {31'h0, imem_req}, 32'h0);
            check("t5_bubble_p", {31'h0, valid_d}, 32'h0);
            tick();
        end
        resume = 1'b1; tick();
        resume = 1'b0;
        check("t5_unpaused", {31'h0, paused}, 32'h0);
        check("t5_req", {31'h0, imem_req}, 32'h1);
        check("t5_addr24r", imem_addr, 32'h24);
        exp_q.push_back(32'h24); tick();
        check("t5_pc24", pc_d, 32'h24);

        // Reset while a request to 0x40 is outstanding
        redirect = 1'b1; redirect_pc = 32'h40; tick();
        redirect = 1'b0; imem_ready = 1'b0;
        check("t6_addr40", imem_addr, 32'h40);
        tick();
        check("t6_addr40_held", imem_addr, 32'h40);
        check("t6_req", {31'h0, imem_req}, 32'h1);
        check("t6_sb_empty", exp_q.size(), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", {31'h0, valid_d}, 32'h0);
        check("t6_rst_instr", instr_d, 32'h0);
        check("t6_rst_pc", pc_d, 32'h0);
        check("t6_rst_paused", {31'h0, paused}, 32'h0);
        check("t6_rst_addr", imem_addr, 32'h0);
        imem_ready = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        check("t6_addr_reset_pc", imem_addr, 32'h0);
        exp_q.push_back(32'h0); tick();
        check("t6_addr4", imem_addr, 32'h4);
        exp_q.push_back(32'h4); tick();
        imem_ready = 1'b0; tick(); tick();
        check("t6_sb_drained", exp_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
